// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore machine).
// Decodes the opcode and sequences every datapath strobe across fetch, decode,
// execute, memory and writeback. Supports R-type, lw, sw, beq, j and addi.
// Undefined opcodes and arithmetic overflow trap into the Cause/EPC path.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset (-> FETCH)
//   opcode[5:0]       IR[31:26]
//   overflow          ALU signed-overflow flag
//   state[3:0]        current state encoding
//   pc_write .. epc_write  datapath strobes, decoded from state only
module mips_multicycle_control #(
  parameter logic EXC_OPUNDEF = 1'b0,
  parameter logic EXC_OVF     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       overflow,
  output logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       int_cause,
  output logic       cause_write,
  output logic       epc_write
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StExcUndef = 4'd10,
    StExcOvf   = 4'd11,
    StAddiEx   = 4'd12,
    StAddiWb   = 4'd13
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d       = StFetch;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    int_cause     = 1'b0;
    cause_write   = 1'b0;
    epc_write     = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed here so BRANCH can use ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000:            state_d = StExecute;
          6'b100011, 6'b101011: state_d = StMemAdr;
          6'b000100:            state_d = StBranch;
          6'b000010:            state_d = StJump;
          6'b001000:            state_d = StAddiEx;
          default:              state_d = StExcUndef;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // lw and sw differ only in opcode[3].
        state_d   = opcode[3] ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = overflow ? StExcOvf : StAluWb;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StExcUndef: begin
        int_cause   = EXC_OPUNDEF;
        cause_write = 1'b1;
        epc_write   = 1'b1;
        pc_write    = 1'b1;
        pc_source   = 2'b11;
      end
      StExcOvf: begin
        int_cause   = EXC_OVF;
        cause_write = 1'b1;
        epc_write   = 1'b1;
        pc_write    = 1'b1;
        pc_source   = 2'b11;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = overflow ? StExcOvf : StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
      // Unreachable encodings: all strobes low, recover to FETCH.
      default: state_d = StFetch;
    endcase
  end

endmodule
